// File: rtl/fib_bcd_conv_pkg.sv
// fib_bcd_conv_pkg: shared widths, FSM encoding and digit-count helper for the BCD converter
package fib_bcd_conv_pkg;

    localparam int BIN_W = 20;
    localparam int NDIG  = 7;
    localparam int CNT_W = 5;
    localparam int BCD_W = 4 * NDIG;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OP   = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    // One plus the index of the highest nonzero digit; an all-zero value still shows one digit.
    function automatic logic [2:0] sig_digits(input logic [BCD_W-1:0] v);
        logic [2:0] n;
        n = 3'd1;
        for (int k = 1; k < NDIG; k++) begin
            if (v[4*k +: 4] != 4'd0) n = 3'(k + 1);
        end
        return n;
    endfunction

endpackage

// File: rtl/fib_bcd_conv_adj3.sv
// bcd_adj3: double-dabble digit correction, adds 3 to a digit of 5 or more
module bcd_adj3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv: sequential 20-bit binary to 7-digit packed BCD converter, one bit per clock
module fib_bcd_conv
    import fib_bcd_conv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             ready,
    output logic             done_tick,
    output logic [BCD_W-1:0] bcd,
    output logic [2:0]       ndig
);

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] p_q, p_d;
    logic [BCD_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [2:0]       ndig_q, ndig_d;
    logic [BCD_W-1:0] w_adj;
    logic [BCD_W-1:0] w_shift;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_adj3 u_adj (
            .d (w_q[4*g +: 4]),
            .q (w_adj[4*g +: 4])
        );
    end

    assign w_shift   = {w_adj[BCD_W-2:0], p_q[BIN_W-1]};
    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign bcd       = bcd_q;
    assign ndig      = ndig_q;

    // Next-state and datapath: load in idle, adjust-and-shift in op, publish results on the last shift.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        w_d     = w_q;
        n_d     = n_q;
        bcd_d   = bcd_q;
        ndig_d  = ndig_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    p_d     = bin;
                    w_d     = '0;
                    n_d     = CNT_W'(BIN_W);
                    state_d = S_OP;
                end
            end
            S_OP: begin
                w_d = w_shift;
                p_d = p_q << 1;
                n_d = n_q - 1'b1;
                if (n_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = w_shift;
                    ndig_d  = sig_digits(w_shift);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and data registers; reset aborts any conversion and shows a single zero digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            w_q     <= '0;
            n_q     <= '0;
            bcd_q   <= '0;
            ndig_q  <= 3'd1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            w_q     <= w_d;
            n_q     <= n_d;
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
        end
    end

endmodule

// File: doc/fib_bcd_conv.md
# fib_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the Fibonacci FSMD. It accepts the 20-bit result `f` when the upstream `done_tick` pulses, and converts it to seven packed BCD digits with the shift-add-3 (double-dabble) algorithm, one bit per clock. It holds the digits and a significant-digit count stable for the seven-segment display stage. The interface is a start/ready/done_tick handshake.

## Interface
- Parameters: none. Widths are fixed by package constants (`BIN_W` = 20, `NDIG` = 7).
- `clk`  in  1  system clock; all registers are rising-edge.
- `reset`  in  1  asynchronous, active-high; returns the FSM to idle and clears all registers.
- `start`  in  1  conversion request; sampled only in idle. Normally wired to the upstream `done_tick`.
- `bin`  in  20  unsigned binary operand; captured on the accepted `start` edge only.
- `ready`  out  1  high while in idle (combinational from state).
- `done_tick`  out  1  one-cycle pulse in the done state; outputs are valid from this cycle onward.
- `bcd`  out  28  result register. Digit k occupies `bcd[4k+3:4k]`; k=0 is the units digit.
- `ndig`  out  3  number of significant digits, 1..7. A value of 0 reports 1.

## Operation
- States:
  - idle: `ready`=1. On `start`=1, load the shift register `p_reg`←`bin`, clear the working digit register `w_reg`←0, set the counter `n_reg`←20, and go to op.
  - op, every cycle:
    - Adjust each working digit: if the digit ≥ 5, add 3, keeping 4 bits.
    - Shift the 28-bit adjusted digit vector left 1, inserting `p_reg[19]` at bit 0.
    - Shift `p_reg` left 1 and decrement `n_reg`.
    - When `n_reg`==1 (the 20th shift), go to done.
  - done: `done_tick`=1, then go to idle unconditionally.
  - Illegal encoding: go to idle.
- Output update:
  - `bcd` and `ndig` load on the op→done edge from the final working value.
  - Both hold unchanged during any later op phase until the next completion.
  - The display never sees partial results.
- `ndig` is one plus the index of the highest nonzero digit, or 1 if all digits are zero. It is computed combinationally from the final working value and registered with `bcd`.
- `start` outside idle is ignored; it is neither queued nor latched.
- `bin` changes outside the accepted start edge have no effect.
- The maximum input 1048575 fits in 7 digits, so there is no overflow condition. No adjusted digit can exceed 4'd12 before the shift.
- Reset mid-operation:
  - State goes to idle and `bcd`=0, `ndig`=1.
  - No `done_tick` is produced for the aborted conversion.

## Timing
- Reset values: `ready`=1 (idle), `done_tick`=0, `bcd`=28'h0, `ndig`=3'd1.
- `start` is accepted at edge E0. Then:
  - op occupies cycles E0+1..E0+20.
  - done occupies cycle E0+21, with `done_tick`=1 and new `bcd`/`ndig` visible.
  - idle with `ready`=1 returns in cycle E0+22.
- Fixed latency: 21 cycles from accepted start to `done_tick`, independent of value. Throughput is one conversion per 22 cycles.
- `start` asserted in the same cycle that `ready` rises (first idle cycle) is accepted.
- Back-to-back upstream `done_tick` pulses closer than 22 cycles drop the later request. The upstream FSMD cannot produce such pulses.

## Structure
- Shared package:
  - `BIN_W`=20, `NDIG`=7, `CNT_W`=5.
  - State encoding: idle=2'b00, op=2'b01, done=2'b10.
  - A function computing the significant-digit count from a 28-bit packed value.
- One sub-module, `bcd_adj3`: a combinational 4-bit digit in, digit+3 out if ≥5, else the digit unchanged. It is instantiated `NDIG` times via generate in the op datapath.
- The rest is a single FSMD with separate state/data registers and next-state logic.

## Test plan
- Reset:
  - Assert `reset` mid-idle, then release.
  - Required: `ready`=1, `done_tick`=0, `bcd`=28'h0000000, `ndig`=1.
- Fibonacci value:
  - `bin`=832040 (F30), `start` for one cycle.
  - Required: `done_tick` exactly 21 cycles later, `bcd`=28'h0832040, `ndig`=6, `ready` back 1 cycle after.
- Boundaries:
  - `bin`=0 → `bcd`=28'h0000000, `ndig`=1.
  - `bin`=1 → `bcd`=28'h0000001, `ndig`=1.
  - `bin`=1048575 → `bcd`=28'h1048575, `ndig`=7.
- Start during op:
  - Convert 6765, pulse `start` with `bin`=99999 at op cycle 5.
  - Required: a single `done_tick`, `bcd`=28'h0006765, `ndig`=4.
  - Outputs held at the prior result until completion.
- Reset mid-op:
  - Assert `reset` at op cycle 10 of converting 832040.
  - Required: no `done_tick`, `bcd`=0, `ndig`=1.
  - A following conversion of 55 gives `bcd`=28'h0000055, `ndig`=2.
- Chained:
  - Drive from the fib block with i=20.
  - Required: `bcd`=28'h0006765 latched 21 cycles after the fib `done_tick`.
